// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory access controller.
// Holds the access-size codes, the controller state type and the lane helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_RMW_WRITE
    } state_t;

    // A half must sit on an even byte and a word on a 4-byte boundary; bytes never misalign.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Little-endian lane insertion of a right-aligned store value into an existing word.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  offset);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{offset, 3'b000} +: 8]     = data[7:0];
            SZ_HALF: w[{offset[1], 4'b0000} +: 16] = data[15:0];
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed little-endian lane of a RAM word and extends it to 32 bits.
// Purely combinational.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_bit;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = rdata[{offset[1], 4'b0000} +: 16];
        sign_bit  = 1'b0;
        data      = rdata;
        case (size)
            SZ_BYTE: begin
                sign_bit = ~load_unsigned & byte_lane[7];
                data     = {{24{sign_bit}}, byte_lane};
            end
            SZ_HALF: begin
                sign_bit = ~load_unsigned & half_lane[15];
                data     = {{16{sign_bit}}, half_lane};
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller between the pipeline and a word-wide synchronous data RAM.
// Word stores finish in one cycle; loads and sub-word stores take two (stall, then complete).
module mem_access_ctrl
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        ram_we,
    output logic [13:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      state, next_state;

    logic [13:0] lat_word;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic        lat_uns;
    logic [31:0] lat_data;

    logic        req;
    logic        illegal;
    logic        capture;
    logic        stall_c;
    logic        we_c;
    logic        err_c;
    logic [31:0] aligned_data;
    logic        unused_addr_hi;

    // Only a 64 KiB window is decoded; upper address bits alias onto it.
    assign unused_addr_hi = ^address[31:16];

    assign req     = mem_read | mem_write;
    assign illegal = (mem_read & mem_write) | (mem_size == 2'b11)
                   | is_misaligned(mem_size, address[1:0]);

    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        we_c       = 1'b0;
        err_c      = 1'b0;
        capture    = 1'b0;
        ram_addr   = address[15:2];
        ram_wdata  = store_data;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (illegal) begin
                        err_c = 1'b1;
                    end else if (mem_read) begin
                        stall_c    = 1'b1;
                        capture    = 1'b1;
                        next_state = ST_LOAD_WAIT;
                    end else if (mem_size == SZ_WORD) begin
                        we_c = 1'b1;
                    end else begin
                        stall_c    = 1'b1;
                        capture    = 1'b1;
                        next_state = ST_RMW_WRITE;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                ram_addr   = lat_word;
                next_state = ST_IDLE;
            end
            ST_RMW_WRITE: begin
                ram_addr   = lat_word;
                ram_wdata  = merge_store(ram_rdata, lat_data, lat_size, lat_off);
                we_c       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Gating with rst_n keeps the RAM write and stall dead for the whole reset, even mid-operation.
    assign stall  = stall_c & rst_n;
    assign ram_we = we_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_word <= '0;
            lat_size <= '0;
            lat_off  <= '0;
            lat_uns  <= 1'b0;
            lat_data <= '0;
        end else if (capture) begin
            lat_word <= address[15:2];
            lat_size <= mem_size;
            lat_off  <= address[1:0];
            lat_uns  <= load_unsigned;
            lat_data <= store_data;
        end
    end

    mem_load_align u_align (
        .rdata         (ram_rdata),
        .size          (lat_size),
        .offset        (lat_off),
        .load_unsigned (lat_uns),
        .data          (aligned_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data  <= '0;
            load_valid <= 1'b0;
            access_err <= 1'b0;
        end else begin
            load_valid <= (state == ST_LOAD_WAIT);
            access_err <= err_c;
            if (state == ST_LOAD_WAIT) begin
                load_data <= aligned_data;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port mem_read, input, 1 bit: load request from the MEM stage.
REQ-004 SHALL have port mem_write, input, 1 bit: store request from the MEM stage.
REQ-005 SHALL have port mem_size, input, 2 bits: access size, 00 byte, 01 half, 10 word; 11 is illegal.
REQ-006 SHALL have port load_unsigned, input, 1 bit: 1 selects zero-extension, 0 selects sign-extension.
REQ-007 SHALL have port address, input, 32 bits: byte address; only [15:0] is used.
REQ-008 SHALL have port store_data, input, 32 bits: store value, right-aligned.
REQ-009 SHALL have port stall, output, 1 bit: holds the pipeline.
REQ-010 SHALL have port load_data, output, 32 bits: extended load result (registered).
REQ-011 SHALL have port load_valid, output, 1 bit: one-cycle pulse marking load_data valid.
REQ-012 SHALL have port access_err, output, 1 bit: one-cycle pulse for a misaligned or illegal request.
REQ-013 SHALL have ports ram_we (1), ram_addr (14, word index = address[15:2]), ram_wdata (32) and ram_rdata (32, input) to the word-wide data RAM; ram_rdata is valid the cycle after ram_addr is presented.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, LOAD_WAIT, RMW_WRITE.
REQ-015 In IDLE with a legal aligned load: drive ram_addr, assert stall, go to LOAD_WAIT.
REQ-016 In LOAD_WAIT: stall=0; extract the lane from ram_rdata; register the extended value into load_data; pulse load_valid next cycle; return to IDLE.
REQ-017 In IDLE with a legal aligned word store: ram_we=1, ram_wdata=store_data, stall=0 (single cycle); stay in IDLE.
REQ-018 In IDLE with a byte or half store: read ram_addr, assert stall, go to RMW_WRITE.
REQ-019 In RMW_WRITE: merge the store lanes into ram_rdata; ram_we=1; stall=0; return to IDLE.
REQ-020 Lane order SHALL be little-endian: byte k = bits [8k+7:8k], k=address[1:0]; half at address[1] selects [31:16] or [15:0].
REQ-021 Misalignment (half with address[0]=1, word with address[1:0]!=0), mem_size=11, or mem_read&mem_write together SHALL cause: no RAM write, no stall, and access_err pulsed the following cycle.
REQ-022 In IDLE, stall SHALL be combinational from the request inputs; in other states it SHALL be 0; every multi-cycle operation occupies exactly 2 cycles.
REQ-023 ram_we SHALL never be asserted in LOAD_WAIT, and never during an illegal request.
REQ-024 Address wrap: address[31:16] SHALL be ignored, so 0x0001_0000 maps to word 0.

Reset
REQ-025 While rst_n=0: state=IDLE, load_data=0, load_valid=0, access_err=0, stall=0, ram_we forced 0 (asynchronous, mid-operation included).
REQ-026 Reset during RMW_WRITE SHALL abort the write with no partial RAM update.

Structure
REQ-027 Package mem_access_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-028 Lane extraction and extension SHALL live in sub-module mem_load_align (combinational), instantiated once.

Verification
REQ-029 RAM word 0x10 = 0x8899AABB; lb at 0x42 (signed) -> stall 1 cycle; load_data=0xFFFFFF99 with load_valid pulsed.
REQ-030 Same word; lhu at 0x40 -> load_data=0x0000AABB.
REQ-031 RAM word 0x10 = 0x11223344; sb 0xEE at 0x41 -> 2 cycles, stall high in first only; word becomes 0x1122EE44.
REQ-032 sw 0xDEADBEEF at 0x44 -> ram_we in the same cycle, stall never high; word 0x11 = 0xDEADBEEF.
REQ-033 lw at 0x42 -> access_err pulse, no stall, ram_we=0, load_valid=0.
REQ-034 Assert rst_n=0 in the RMW_WRITE cycle of sh 0x5555 at 0x40 -> RAM unchanged; FSM in IDLE after release.
